// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encoding and pipeline control-word bit positions
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;
  localparam int REG_W = 5;
  localparam int WB_MEMTOREG = 2;
  localparam int MEM_BRANCH = 3;
  localparam int MEM_JUMP = 5;
  function automatic logic is_load(input logic [3:0] wb_control);
    return wb_control[WB_MEMTOREG];
  endfunction
  function automatic logic is_redirect(input logic [7:0] mem_control, input logic cond);
    return (mem_control[MEM_BRANCH] & cond) | mem_control[MEM_JUMP];
  endfunction
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         inc,
  output logic [W-1:0] value
);
  always_ff @(posedge CLK)
    value <= RESET ? '0 : (inc & ~&value) ? value + 1'b1 : value;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for load-use, MEM-resolved redirects and dmem waits
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ex_MemtoReg,
  input  logic [REG_W-1:0] ex_RegDst,
  input  logic [REG_W-1:0] id_Rs1,
  input  logic [REG_W-1:0] id_Rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             mem_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_Enable,
  output logic             IFID_Enable,
  output logic             IDEX_Enable,
  output logic             EXMEM_Enable,
  output logic             MEMWB_Enable,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EXMEM_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count,
  output logic             wait_timeout
);
  localparam int WC_W = $clog2(WAIT_LIMIT + 1);
  state_t r_state, w_next;
  logic [WC_W-1:0] r_wait_cnt;
  logic r_timeout;
  logic w_lu, w_mwait, w_redir, w_lu_stall;
  assign w_lu = ex_MemtoReg & (|ex_RegDst) &
                ((id_uses_rs1 & (id_Rs1 == ex_RegDst)) | (id_uses_rs2 & (id_Rs2 == ex_RegDst)));
  assign w_mwait = dmem_req & ~dmem_ready;
  assign w_redir = mem_redirect & ~w_mwait;
  // ID holds a flushed bubble right after a redirect, so its sources are meaningless
  assign w_lu_stall = w_lu & ~w_mwait & ~mem_redirect & (r_state != REDIRECT);
  always_ff @(posedge CLK)
    r_state <= RESET ? RUN : w_next;
  always_comb
    w_next = w_mwait ? MEM_WAIT : mem_redirect ? REDIRECT : RUN;
  always_comb begin
    PC_Enable    = ~RESET & ~w_mwait & ~w_lu_stall;
    IFID_Enable  = ~RESET & ~w_mwait & ~w_lu_stall;
    IDEX_Enable  = ~RESET & ~w_mwait;
    EXMEM_Enable = ~RESET & ~w_mwait;
    MEMWB_Enable = ~RESET & ~w_mwait;
    IFID_flush   = RESET | w_redir;
    IDEX_flush   = RESET | w_redir | w_lu_stall;
    EXMEM_flush  = RESET | w_redir;
  end
  // watchdog only flags a hung access; the stall itself is never released by it
  always_ff @(posedge CLK)
    if (RESET) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= !w_mwait ? '0 : (r_wait_cnt == WC_W'(WAIT_LIMIT)) ? r_wait_cnt : r_wait_cnt + 1'b1;
      r_timeout  <= r_timeout | (w_mwait & (r_wait_cnt >= WC_W'(WAIT_LIMIT - 1)));
    end
  assign wait_timeout = r_timeout;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK(CLK), .RESET(RESET), .inc(~PC_Enable), .value(stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .CLK(CLK), .RESET(RESET), .inc(w_redir), .value(redirect_count)
  );
endmodule
